// File: rtl/key_debounce_pulser_if.sv
// Key conditioning bus: raw active-low KEY inputs and the debounced level/pulse outputs.
interface key_debounce_pulser_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] KEY;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_pulse;
    logic [N_KEYS-1:0] key_release;
    logic              any_pulse;
    logic [1:0]        key_id;

    modport master (
        output KEY,
        input  key_level, key_pulse, key_release, any_pulse, key_id
    );

    modport slave (
        input  KEY,
        output key_level, key_pulse, key_release, any_pulse, key_id
    );
endinterface

// File: rtl/key_debounce_pulser.sv
// Synchronises, debounces and edge-detects the active-low DE1-SoC push-buttons;
// each accepted press/release yields exactly one single-cycle pulse.
module key_debounce_pulser #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    key_debounce_pulser_if.slave  kif
);
    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        REL_PEND
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;
    logic [N_KEYS-1:0] w_s;

    state_t            r_state     [N_KEYS];
    state_t            w_state_nxt [N_KEYS];
    logic [CNT_W-1:0]  r_cnt       [N_KEYS];
    logic [CNT_W-1:0]  w_cnt_nxt   [N_KEYS];

    logic [N_KEYS-1:0] w_pulse_nxt;
    logic [N_KEYS-1:0] w_rel_nxt;
    logic [N_KEYS-1:0] w_level_nxt;
    logic              w_any_nxt;
    logic [1:0]        w_id_nxt;

    logic [N_KEYS-1:0] r_level;
    logic [N_KEYS-1:0] r_pulse;
    logic [N_KEYS-1:0] r_release;
    logic              r_any;
    logic [1:0]        r_id;

    assign w_s = ~r_sync2;

    always_comb begin
        w_pulse_nxt = '0;
        w_rel_nxt   = '0;
        w_level_nxt = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                RELEASED: begin
                    if (w_s[i]) begin
                        w_state_nxt[i] = PRESS_PEND;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                PRESS_PEND: begin
                    if (!w_s[i]) begin
                        w_state_nxt[i] = RELEASED;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_state_nxt[i] = PRESSED;
                        w_pulse_nxt[i] = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!w_s[i]) begin
                        w_state_nxt[i] = REL_PEND;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                REL_PEND: begin
                    if (w_s[i]) begin
                        w_state_nxt[i] = PRESSED;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_state_nxt[i] = RELEASED;
                        w_rel_nxt[i]   = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                    end
                end
                default: w_state_nxt[i] = RELEASED;
            endcase
            w_level_nxt[i] = (w_state_nxt[i] == PRESSED) || (w_state_nxt[i] == REL_PEND);
        end

        // Scan downward so the lowest pulsing index is the final assignment.
        w_any_nxt = |w_pulse_nxt;
        w_id_nxt  = '0;
        for (int unsigned i = N_KEYS; i > 0; i--) begin
            if (w_pulse_nxt[i-1]) w_id_nxt = 2'(i - 1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sync1   <= '1;
            r_sync2   <= '1;
            r_level   <= '0;
            r_pulse   <= '0;
            r_release <= '0;
            r_any     <= 1'b0;
            r_id      <= '0;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                r_state[i] <= RELEASED;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_sync1   <= kif.KEY;
            r_sync2   <= r_sync1;
            r_level   <= w_level_nxt;
            r_pulse   <= w_pulse_nxt;
            r_release <= w_rel_nxt;
            r_any     <= w_any_nxt;
            r_id      <= w_id_nxt;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    assign kif.key_level   = r_level;
    assign kif.key_pulse   = r_pulse;
    assign kif.key_release = r_release;
    assign kif.any_pulse   = r_any;
    assign kif.key_id      = r_id;
endmodule

// File: tb/tb_key_debounce_pulser.sv
// Bench for key_debounce_pulser: directed scenarios plus random key activity, all
// checked every cycle against a sample-window reference model.
module tb_key_debounce_pulser;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_debounce_pulser_if #(.N_KEYS(4)) kif ();

    key_debounce_pulser #(
        .N_KEYS(4),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(4)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .kif(kif)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: KEY delay line, accepted level, and number of consecutive
    // synchronised samples disagreeing with the accepted level.
    logic [3:0] m_d1 = '1;
    logic [3:0] m_d2 = '1;
    logic [3:0] m_lvl = '0;
    int         m_run [4] = '{0, 0, 0, 0};
    logic [3:0] e_pulse = '0;
    logic [3:0] e_rel = '0;
    logic       e_any = 1'b0;
    logic [1:0] e_id = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] k, input logic r);
        logic [3:0] s;
        kif.KEY = k;
        rst     = r;
        @(posedge clk);
        e_pulse = '0;
        e_rel   = '0;
        if (r) begin
            m_d1  = '1;
            m_d2  = '1;
            m_lvl = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            s    = ~m_d2;
            m_d2 = m_d1;
            m_d1 = k;
            for (int i = 0; i < 4; i++) begin
                if (s[i] != m_lvl[i]) begin
                    m_run[i]++;
                    // accepted once D+1 consecutive samples disagree
                    if (m_run[i] == D + 1) begin
                        m_lvl[i] = ~m_lvl[i];
                        if (m_lvl[i]) e_pulse[i] = 1'b1;
                        else          e_rel[i]   = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        e_any = |e_pulse;
        e_id  = '0;
        for (int i = 3; i >= 0; i--) if (e_pulse[i]) e_id = 2'(i);
        #1;
        check_eq("key_level",   32'(kif.key_level),   32'(m_lvl));
        check_eq("key_pulse",   32'(kif.key_pulse),   32'(e_pulse));
        check_eq("key_release", 32'(kif.key_release), 32'(e_rel));
        check_eq("any_pulse",   32'(kif.any_pulse),   32'(e_any));
        check_eq("key_id",      32'(kif.key_id),      32'(e_id));
    endtask

    task automatic hold(input logic [3:0] k, input int n);
        for (int i = 0; i < n; i++) step(k, 1'b0);
    endtask

    initial begin
        int np;
        int drops;
        int tmr [4];
        logic [3:0] kv;

        kif.KEY = '1;
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1);
        check_eq("reset_outputs", 32'({kif.key_level, kif.key_pulse, kif.key_release,
                                       kif.any_pulse, kif.key_id}), 32'd0);

        // clean press then release of KEY[0]
        hold(4'b1110, 20);
        hold(4'b1111, 20);

        // bounce on KEY[1]
        hold(4'b1101, 5);
        hold(4'b1111, 2);
        hold(4'b1101, 20);
        hold(4'b1111, 20);

        // simultaneous KEY[3] and KEY[2]
        hold(4'b0011, 20);
        hold(4'b1111, 20);

        // reset while KEY[0] press is pending (cnt=4), key held through reset
        hold(4'b1110, 7);
        step(4'b1110, 1'b1);
        hold(4'b1110, 20);
        hold(4'b1111, 20);

        // long hold of KEY[2]
        np    = 0;
        drops = 0;
        for (int i = 0; i < 100; i++) begin
            step(4'b1011, 1'b0);
            if (kif.key_pulse[2]) np++;
            if (i >= 10 && !kif.key_level[2]) drops++;
        end
        check_eq("long_hold_pulses", 32'(np), 32'd1);
        check_eq("long_hold_level_drops", 32'(drops), 32'd0);
        hold(4'b1111, 20);

        // random per-key hold times, mixing glitches with stable periods, rare resets
        kv = '1;
        for (int i = 0; i < 4; i++) tmr[i] = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (tmr[i] == 0) begin
                    kv[i]  = ~kv[i];
                    tmr[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                                         : int'($urandom_range(8, 30));
                end else begin
                    tmr[i]--;
                end
            end
            step(kv, ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
